// File: rtl/ramb16_s18_bit_reader.sv
// ============================================================================
// Module      : ramb16_s18_bit_reader
// Description : Streams words from a 16+2-bit block-RAM read port as a serial
//               valid/ready bit stream, prefetching the next word to avoid gaps.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ramb16_s18_bit_reader #(
    parameter int   INCLUDE_PARITY = 1,
    parameter logic SRVAL_OUT      = 1'b0
) (
    input  logic        CLK,
    input  logic        SSR,
    input  logic        START,
    input  logic [9:0]  BASE_ADDR,
    input  logic [10:0] LEN,
    output logic [9:0]  ADDR,
    output logic        EN,
    input  logic [15:0] DO,
    input  logic [1:0]  DOP,
    output logic        DOUT,
    output logic        DOUT_VALID,
    input  logic        DOUT_READY,
    output logic        BUSY,
    output logic        DONE
);

    localparam int         C_BITS     = (INCLUDE_PARITY != 0) ? 18 : 16;
    localparam logic [4:0] C_LAST_BIT = 5'(C_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_SHIFT  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  addr_q, addr_d;
    logic        en_q, en_d;
    logic        pend_q, pend_d;
    logic [17:0] sh_q, sh_d;
    logic [4:0]  bit_q, bit_d;
    logic        valid_q, valid_d;
    logic        dout_q, dout_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [17:0] hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d;
    logic [10:0] words_left_q, words_left_d;
    logic [10:0] fetch_left_q, fetch_left_d;

    logic        w_xfer;
    logic        w_need_load;
    logic        w_have_word;
    logic        w_take_do;
    logic [17:0] w_word;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        en_d         = 1'b0;
        pend_d       = en_q;
        sh_d         = sh_q;
        bit_d        = bit_q;
        valid_d      = valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        words_left_d = words_left_q;
        fetch_left_d = fetch_left_q;

        w_xfer      = valid_q & DOUT_READY;
        w_need_load = (state_q == S_LOAD) ||
                      ((state_q == S_SHIFT) && (!valid_q || (w_xfer && (bit_q == C_LAST_BIT))));
        w_have_word = hold_valid_q | pend_q;
        w_word      = hold_valid_q ? hold_q : {DOP, DO};
        // RAM data goes straight to the shift register only when nothing is parked
        w_take_do   = w_need_load && (words_left_q != 11'd0) && !hold_valid_q && pend_q;

        unique case (state_q)
            S_IDLE, S_FINISH: begin
                state_d = S_IDLE;
                if (START) begin
                    if (LEN == 11'd0) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = S_FETCH;
                        en_d         = 1'b1;
                        addr_d       = BASE_ADDR;
                        busy_d       = 1'b1;
                        words_left_d = LEN;
                        fetch_left_d = LEN - 11'd1;
                    end
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD, S_SHIFT: begin
                if (w_xfer && (bit_q != C_LAST_BIT)) begin
                    sh_d  = {1'b0, sh_q[17:1]};
                    bit_d = bit_q + 5'd1;
                end
                if (w_need_load) begin
                    if (words_left_q == 11'd0) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        valid_d = 1'b0;
                        bit_d   = 5'd0;
                    end else if (w_have_word) begin
                        state_d      = S_SHIFT;
                        sh_d         = w_word;
                        bit_d        = 5'd0;
                        valid_d      = 1'b1;
                        words_left_d = words_left_q - 11'd1;
                        hold_valid_d = 1'b0;
                        // Prefetch only while the holding register is free
                        if (fetch_left_q != 11'd0) begin
                            en_d         = 1'b1;
                            addr_d       = addr_q + 10'd1;
                            fetch_left_d = fetch_left_q - 11'd1;
                        end
                    end else begin
                        valid_d = 1'b0;
                        bit_d   = 5'd0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pend_q && !w_take_do) begin
            hold_d       = {DOP, DO};
            hold_valid_d = 1'b1;
        end

        dout_d = valid_d ? sh_d[0] : SRVAL_OUT;
    end

    always_ff @(posedge CLK) begin
        if (SSR) begin
            state_q      <= S_IDLE;
            addr_q       <= 10'd0;
            en_q         <= 1'b0;
            pend_q       <= 1'b0;
            sh_q         <= 18'd0;
            bit_q        <= 5'd0;
            valid_q      <= 1'b0;
            dout_q       <= SRVAL_OUT;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hold_q       <= 18'd0;
            hold_valid_q <= 1'b0;
            words_left_q <= 11'd0;
            fetch_left_q <= 11'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            en_q         <= en_d;
            pend_q       <= pend_d;
            sh_q         <= sh_d;
            bit_q        <= bit_d;
            valid_q      <= valid_d;
            dout_q       <= dout_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            words_left_q <= words_left_d;
            fetch_left_q <= fetch_left_d;
        end
    end

    assign ADDR       = addr_q;
    assign EN         = en_q;
    assign DOUT       = dout_q;
    assign DOUT_VALID = valid_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ramb16_s18_bit_reader.sv
// ============================================================================
// Module      : tb_ramb16_s18_bit_reader
// Description : Scoreboard bench for ramb16_s18_bit_reader with a BRAM model.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ramb16_s18_bit_reader;

    logic        CLK = 1'b0;
    logic        SSR, START, DOUT_READY;
    logic [9:0]  BASE_ADDR;
    logic [10:0] LEN;
    logic [9:0]  ADDR;
    logic        EN;
    logic [15:0] DO;
    logic [1:0]  DOP;
    logic        DOUT, DOUT_VALID, BUSY, DONE;

    logic        start_b;
    logic [9:0]  base_b;
    logic [10:0] len_b;
    logic [9:0]  addr_b;
    logic        en_b;
    logic [15:0] do_b;
    logic [1:0]  dop_b;
    logic        dout_b, valid_b, busy_b, done_b;

    logic [17:0] mem [1024];
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;
    int          c0;

    logic        exp_bits [$];
    logic [9:0]  exp_addr [$];
    int          en_cnt, done_cnt, done_cyc, xfer_cnt, first_v, last_x;
    logic        busy_at_done, prev_stall, prev_dout, mon_bit;
    logic [9:0]  mon_addr;

    always #5 CLK = ~CLK;

    ramb16_s18_bit_reader u_dut (
        .CLK(CLK), .SSR(SSR), .START(START), .BASE_ADDR(BASE_ADDR), .LEN(LEN),
        .ADDR(ADDR), .EN(EN), .DO(DO), .DOP(DOP), .DOUT(DOUT),
        .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY), .BUSY(BUSY), .DONE(DONE)
    );

    ramb16_s18_bit_reader #(.INCLUDE_PARITY(0), .SRVAL_OUT(1'b1)) u_dut16 (
        .CLK(CLK), .SSR(SSR), .START(start_b), .BASE_ADDR(base_b), .LEN(len_b),
        .ADDR(addr_b), .EN(en_b), .DO(do_b), .DOP(dop_b), .DOUT(dout_b),
        .DOUT_VALID(valid_b), .DOUT_READY(1'b1), .BUSY(busy_b), .DONE(done_b)
    );

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (EN === 1'b1) {DOP, DO} <= mem[ADDR];
        if (en_b === 1'b1) {dop_b, do_b} <= mem[addr_b];
    end

    // Scoreboard monitor for the parity-enabled instance
    always @(negedge CLK) begin
        if (EN === 1'b1) begin
            en_cnt++;
            total++;
            if (exp_addr.size() == 0)
                $display("FAIL en_addr: unexpected EN with ADDR=%0d, required no read", ADDR);
            else begin
                mon_addr = exp_addr.pop_front();
                if (ADDR !== mon_addr) $display("FAIL en_addr: ADDR=%0d required %0d", ADDR, mon_addr);
                else passed++;
            end
        end
        if (DONE === 1'b1) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = BUSY;
        end
        if (DOUT_VALID === 1'b1 && first_v < 0) first_v = cyc;
        if (prev_stall) begin
            total++;
            if (DOUT_VALID !== 1'b1 || DOUT !== prev_dout)
                $display("FAIL stall_hold: DOUT=%b VALID=%b required DOUT=%b VALID=1", DOUT, DOUT_VALID, prev_dout);
            else passed++;
        end
        if (DOUT_VALID === 1'b1 && DOUT_READY === 1'b1) begin
            xfer_cnt++;
            last_x = cyc;
            total++;
            if (exp_bits.size() == 0)
                $display("FAIL dout_bit: extra bit %b, required none", DOUT);
            else begin
                mon_bit = exp_bits.pop_front();
                if (DOUT !== mon_bit) $display("FAIL dout_bit: bit %0d DOUT=%b required %b", xfer_cnt - 1, DOUT, mon_bit);
                else passed++;
            end
        end
        prev_stall = (DOUT_VALID === 1'b1) && (DOUT_READY === 1'b0);
        prev_dout  = DOUT;
    end

    task automatic reset_mon();
        en_cnt = 0; done_cnt = 0; done_cyc = -1; xfer_cnt = 0;
        first_v = -1; last_x = -1; busy_at_done = 1'bx;
    endtask

    // Called just after a rising edge; START is high for exactly one cycle
    task automatic start_a(input logic [9:0] base, input logic [10:0] len);
        logic [9:0] a;
        START = 1'b1; BASE_ADDR = base; LEN = len;
        c0 = cyc;
        for (int w = 0; w < int'(len); w++) begin
            a = base + 10'(w);
            exp_addr.push_back(a);
            for (int b = 0; b < 18; b++) exp_bits.push_back(mem[a][b]);
        end
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input int target, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (done_cnt >= target) break;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset();
        SSR = 1'b1; START = 1'b0; start_b = 1'b0; DOUT_READY = 1'b1;
        BASE_ADDR = 10'd0; LEN = 11'd0; base_b = 10'd0; len_b = 11'd0;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({EN, ADDR, DOUT_VALID, DOUT, BUSY, DONE} !== 15'd0)
            $display("FAIL reset_a: EN=%b ADDR=%0d VALID=%b DOUT=%b BUSY=%b DONE=%b required all 0",
                     EN, ADDR, DOUT_VALID, DOUT, BUSY, DONE);
        else passed++;
        total++;
        if (dout_b !== 1'b1 || valid_b !== 1'b0 || en_b !== 1'b0)
            $display("FAIL reset_b: DOUT=%b VALID=%b EN=%b required 1,0,0", dout_b, valid_b, en_b);
        else passed++;
        SSR = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_single();
        reset_mon();
        start_a(10'd5, 11'd1);
        total++;
        if (EN !== 1'b1 || ADDR !== 10'd5 || BUSY !== 1'b1)
            $display("FAIL single_issue: EN=%b ADDR=%0d BUSY=%b required 1,5,1", EN, ADDR, BUSY);
        else passed++;
        wait_done(1, 60);
        total++;
        if (done_cnt !== 1 || done_cyc !== c0 + 21)
            $display("FAIL single_done: count=%0d cycle=%0d required 1 at %0d", done_cnt, done_cyc - c0, 21);
        else passed++;
        total++;
        if (first_v !== c0 + 3 || last_x !== c0 + 20 || xfer_cnt !== 18)
            $display("FAIL single_window: first=%0d last=%0d bits=%0d required 3,20,18", first_v - c0, last_x - c0, xfer_cnt);
        else passed++;
        total++;
        if (busy_at_done !== 1'b0 || en_cnt !== 1 || exp_bits.size() != 0)
            $display("FAIL single_tail: busy=%b en=%0d left=%0d required 0,1,0", busy_at_done, en_cnt, exp_bits.size());
        else passed++;
    endtask

    task automatic test_len0();
        reset_mon();
        @(posedge CLK); #1;
        start_a(10'd33, 11'd0);
        total++;
        if (DONE !== 1'b1 || EN !== 1'b0 || BUSY !== 1'b0)
            $display("FAIL len0_c1: DONE=%b EN=%b BUSY=%b required 1,0,0", DONE, EN, BUSY);
        else passed++;
        repeat (5) @(posedge CLK);
        #1;
        total++;
        if (en_cnt !== 0 || first_v !== -1 || done_cnt !== 1 || DOUT !== 1'b0)
            $display("FAIL len0_after: en=%0d first=%0d done=%0d DOUT=%b required 0,-1,1,0", en_cnt, first_v, done_cnt, DOUT);
        else passed++;
    endtask

    task automatic test_wrap();
        reset_mon();
        start_a(10'd1022, 11'd3);
        wait_done(1, 120);
        total++;
        if (done_cnt !== 1 || en_cnt !== 3 || xfer_cnt !== 54)
            $display("FAIL wrap_count: done=%0d en=%0d bits=%0d required 1,3,54", done_cnt, en_cnt, xfer_cnt);
        else passed++;
        total++;
        if (last_x - first_v + 1 !== 54)
            $display("FAIL wrap_gapless: span=%0d required 54", last_x - first_v + 1);
        else passed++;
    endtask

    task automatic test_stall();
        reset_mon();
        start_a(10'd300, 11'd2);
        for (int i = 0; i < 300 && done_cnt == 0; i++) begin
            @(posedge CLK); #1;
            DOUT_READY = ~DOUT_READY;
        end
        DOUT_READY = 1'b1;
        total++;
        if (done_cnt !== 1 || xfer_cnt !== 36 || en_cnt !== 2 || exp_bits.size() != 0)
            $display("FAIL stall_totals: done=%0d bits=%0d en=%0d left=%0d required 1,36,2,0",
                     done_cnt, xfer_cnt, en_cnt, exp_bits.size());
        else passed++;
    endtask

    task automatic test_restart_ignored();
        reset_mon();
        @(posedge CLK); #1;
        start_a(10'd400, 11'd2);
        repeat (4) @(posedge CLK);
        #1;
        START = 1'b1; BASE_ADDR = 10'd7; LEN = 11'd5;
        @(posedge CLK); #1;
        START = 1'b0;
        wait_done(1, 120);
        repeat (30) @(posedge CLK);
        #1;
        total++;
        if (done_cnt !== 1 || xfer_cnt !== 36 || en_cnt !== 2)
            $display("FAIL restart_ignored: done=%0d bits=%0d en=%0d required 1,36,2", done_cnt, xfer_cnt, en_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        reset_mon();
        start_a(10'd5, 11'd1);
        for (int i = 0; i < 40 && cyc < c0 + 21; i++) begin
            @(posedge CLK); #1;
        end
        total++;
        if (DONE !== 1'b1 || BUSY !== 1'b0)
            $display("FAIL b2b_done: DONE=%b BUSY=%b required 1,0", DONE, BUSY);
        else passed++;
        start_a(10'd9, 11'd1);
        total++;
        if (EN !== 1'b1 || ADDR !== 10'd9 || BUSY !== 1'b1)
            $display("FAIL b2b_issue: EN=%b ADDR=%0d BUSY=%b required 1,9,1", EN, ADDR, BUSY);
        else passed++;
        wait_done(2, 60);
        total++;
        if (done_cnt !== 2 || xfer_cnt !== 36)
            $display("FAIL b2b_totals: done=%0d bits=%0d required 2,36", done_cnt, xfer_cnt);
        else passed++;
    endtask

    task automatic test_no_parity();
        logic q [$];
        int   n;
        n = 0;
        @(posedge CLK); #1;
        start_b = 1'b1; base_b = 10'd5; len_b = 11'd1;
        for (int b = 0; b < 16; b++) q.push_back(mem[5][b]);
        @(posedge CLK); #1;
        start_b = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (valid_b === 1'b1) begin
                n++;
                total++;
                if (q.size() == 0) $display("FAIL np_bit: extra bit %b, required none", dout_b);
                else if (dout_b !== q[0]) $display("FAIL np_bit: bit %0d DOUT=%b required %b", n - 1, dout_b, q[0]);
                else passed++;
                if (q.size() != 0) void'(q.pop_front());
            end
            if (done_b === 1'b1) break;
        end
        total++;
        if (n !== 16 || done_b !== 1'b1 || dout_b !== 1'b1)
            $display("FAIL np_count: bits=%0d done=%b idle_dout=%b required 16,1,1", n, done_b, dout_b);
        else passed++;
    endtask

    task automatic test_abort();
        int en_before;
        reset_mon();
        @(posedge CLK); #1;
        start_a(10'd100, 11'd4);
        for (int i = 0; i < 100 && xfer_cnt < 7; i++) begin
            @(posedge CLK); #1;
        end
        SSR = 1'b1;
        @(posedge CLK); #1;
        SSR = 1'b0;
        total++;
        if (DOUT_VALID !== 1'b0 || EN !== 1'b0 || BUSY !== 1'b0 || DOUT !== 1'b0)
            $display("FAIL abort_state: VALID=%b EN=%b BUSY=%b DOUT=%b required 0,0,0,0", DOUT_VALID, EN, BUSY, DOUT);
        else passed++;
        exp_bits.delete();
        exp_addr.delete();
        repeat (30) @(posedge CLK);
        #1;
        total++;
        if (done_cnt !== 0 || xfer_cnt !== 8)
            $display("FAIL abort_nodone: done=%0d bits=%0d required 0,8", done_cnt, xfer_cnt);
        else passed++;
        en_before = en_cnt;
        SSR = 1'b1; START = 1'b1; BASE_ADDR = 10'd50; LEN = 11'd1;
        @(posedge CLK); #1;
        SSR = 1'b0; START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if (en_cnt !== en_before || BUSY !== 1'b0 || done_cnt !== 0)
            $display("FAIL ssr_priority: en=%0d busy=%b done=%0d required %0d,0,0", en_cnt, BUSY, done_cnt, en_before);
        else passed++;
        reset_mon();
        start_a(10'd200, 11'd1);
        wait_done(1, 60);
        total++;
        if (done_cnt !== 1 || xfer_cnt !== 18 || en_cnt !== 1)
            $display("FAIL abort_rerun: done=%0d bits=%0d en=%0d required 1,18,1", done_cnt, xfer_cnt, en_cnt);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 18'($urandom);
        mem[5] = {2'b10, 16'hA5C3};
        prev_stall = 1'b0;
        prev_dout  = 1'b0;
        reset_mon();
        test_reset();
        test_single();
        test_len0();
        test_wrap();
        test_stall();
        test_restart_ignored();
        test_back_to_back();
        test_no_parity();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
